// File: rtl/vram_arb_pkg.sv
// vram_arbiter shared types: FSM states, grant codes, frame-buffer geometry.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_DISP = 2'b01;
  localparam logic [1:0] GNT_HOST = 2'b10;
  localparam logic [1:0] GNT_ALG  = 2'b11;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;

endpackage

// File: rtl/vram_arb_rr.sv
// Winner select: display strict priority, host/algorithm round-robin.
module vram_arb_rr
  import vram_arb_pkg::*;
(
  input  logic       disp_req,
  input  logic       host_req,
  input  logic       alg_req,
  input  logic       rr_host_next,
  output logic [1:0] grant
);

  always_comb begin
    grant = GNT_NONE;
    if (disp_req)
      grant = GNT_DISP;
    else if (host_req && alg_req)
      grant = rr_host_next ? GNT_HOST : GNT_ALG;
    else if (host_req)
      grant = GNT_HOST;
    else if (alg_req)
      grant = GNT_ALG;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-owner frame-buffer RAM port arbiter (display/host/algorithm).
// Optional range check: define VRAM_ARB_RANGE_CHECK_EN.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 8,
  parameter int MEM_LAT   = 3,
  parameter int MEM_DEPTH = FB_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_req,
  input  logic              host_req,
  input  logic              alg_req,
  input  logic              host_we,
  input  logic              alg_we,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [ADDR_W-1:0] alg_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [DATA_W-1:0] alg_wdata,
  output logic              disp_ack,
  output logic              host_ack,
  output logic              alg_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic [DATA_W-1:0] alg_rdata,
  output logic              host_err,
  output logic              alg_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        grant_id
);

  localparam logic [3:0] LAT_LD = 4'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("vram_arbiter: MEM_LAT out of range");
  end
  if (MEM_DEPTH < 1 || MEM_DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("vram_arbiter: MEM_DEPTH exceeds address space");
  end

  state_t            state;
  logic [3:0]        lat_cnt;
  logic              rr_host_next;
  logic [1:0]        win;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;

  vram_arb_rr u_rr (
    .disp_req     (disp_req),
    .host_req     (host_req),
    .alg_req      (alg_req),
    .rr_host_next (rr_host_next),
    .grant        (win)
  );

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    unique case (win)
      GNT_DISP: sel_addr = disp_addr;
      GNT_HOST: begin
        sel_addr  = host_addr;
        sel_we    = host_we;
        sel_wdata = host_wdata;
      end
      GNT_ALG: begin
        sel_addr  = alg_addr;
        sel_we    = alg_we;
        sel_wdata = alg_wdata;
      end
      default: ;
    endcase
  end

`ifdef VRAM_ARB_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(MEM_DEPTH);
  logic oor;
  assign oor = (win == GNT_HOST || win == GNT_ALG)
            && ({1'b0, sel_addr} >= DEPTH);
`else
  assign host_err = 1'b0;
  assign alg_err  = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      lat_cnt      <= '0;
      rr_host_next <= 1'b1;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      disp_ack     <= 1'b0;
      host_ack     <= 1'b0;
      alg_ack      <= 1'b0;
      disp_rdata   <= '0;
      host_rdata   <= '0;
      alg_rdata    <= '0;
      busy         <= 1'b0;
      grant_id     <= GNT_NONE;
`ifdef VRAM_ARB_RANGE_CHECK_EN
      host_err     <= 1'b0;
      alg_err      <= 1'b0;
`endif
    end else begin
      disp_ack <= 1'b0;
      host_ack <= 1'b0;
      alg_ack  <= 1'b0;
`ifdef VRAM_ARB_RANGE_CHECK_EN
      host_err <= 1'b0;
      alg_err  <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (win != GNT_NONE) begin
            grant_id <= win;
            busy     <= 1'b1;
            // Pointer favours whichever of host/alg just lost
            if (win == GNT_HOST)
              rr_host_next <= 1'b0;
            else if (win == GNT_ALG)
              rr_host_next <= 1'b1;
`ifdef VRAM_ARB_RANGE_CHECK_EN
            if (oor) begin
              state  <= S_RESP;
              mem_we <= 1'b0;
              if (win == GNT_HOST) begin
                host_ack   <= 1'b1;
                host_err   <= 1'b1;
                host_rdata <= '0;
              end else begin
                alg_ack   <= 1'b1;
                alg_err   <= 1'b1;
                alg_rdata <= '0;
              end
            end else
`endif
            begin
              mem_addr  <= sel_addr;
              mem_we    <= sel_we;
              mem_wdata <= sel_wdata;
              lat_cnt   <= LAT_LD;
              state     <= S_ACCESS;
            end
          end else begin
            mem_we <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (lat_cnt == '0) begin
            mem_we <= 1'b0;
            state  <= S_RESP;
            unique case (grant_id)
              GNT_DISP: begin
                disp_ack   <= 1'b1;
                disp_rdata <= mem_rdata;
              end
              GNT_HOST: begin
                host_ack <= 1'b1;
                if (!mem_we) host_rdata <= mem_rdata;
              end
              GNT_ALG: begin
                alg_ack <= 1'b1;
                if (!mem_we) alg_rdata <= mem_rdata;
              end
              default: ;
            endcase
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_RESP: begin
          state    <= S_IDLE;
          grant_id <= GNT_NONE;
          busy     <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a RAM model.
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        disp_req = 0, host_req = 0, alg_req = 0;
  logic        host_we = 0, alg_we = 0;
  logic [16:0] disp_addr = '0, host_addr = '0, alg_addr = '0;
  logic [7:0]  host_wdata = '0, alg_wdata = '0;
  logic        disp_ack, host_ack, alg_ack;
  logic [7:0]  disp_rdata, host_rdata, alg_rdata;
  logic        host_err, alg_err;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic [1:0]  grant_id;

  vram_arbiter dut (
    .clock(clock), .reset(reset),
    .disp_req(disp_req), .host_req(host_req), .alg_req(alg_req),
    .host_we(host_we), .alg_we(alg_we),
    .disp_addr(disp_addr), .host_addr(host_addr), .alg_addr(alg_addr),
    .host_wdata(host_wdata), .alg_wdata(alg_wdata),
    .disp_ack(disp_ack), .host_ack(host_ack), .alg_ack(alg_ack),
    .disp_rdata(disp_rdata), .host_rdata(host_rdata),
    .alg_rdata(alg_rdata),
    .host_err(host_err), .alg_err(alg_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  // RAM model: word i initialised to i[7:0] ^ 0xA5
  logic [7:0] ram [0:76799];
  initial for (int i = 0; i < 76800; i++) ram[i] = i[7:0] ^ 8'hA5;
  assign mem_rdata = (mem_addr < 17'd76800) ? ram[mem_addr] : 8'hEE;
  always @(posedge clock)
    if (mem_we && mem_addr < 17'd76800) ram[mem_addr] <= mem_wdata;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  int we_cnt = 0;
  bit auto_drop = 1;
  logic [1:0] log_id[$];
  int         log_cyc[$];
  logic       log_err[$];

  always @(negedge clock) begin
    if (mem_we) we_cnt++;
    if (disp_ack) begin
      log_id.push_back(2'b01); log_cyc.push_back(cyc);
      log_err.push_back(1'b0);
      if (auto_drop) disp_req = 0;
    end
    if (host_ack) begin
      log_id.push_back(2'b10); log_cyc.push_back(cyc);
      log_err.push_back(host_err);
      if (auto_drop) host_req = 0;
    end
    if (alg_ack) begin
      log_id.push_back(2'b11); log_cyc.push_back(cyc);
      log_err.push_back(alg_err);
      if (auto_drop) alg_req = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic wait_log(input string tag, input int n);
    int k = 0;
    while (log_id.size() < n && k < 60) begin
      @(negedge clock); #1; k++;
    end
    chk(tag, log_id.size(), n);
  endtask

  task automatic clear_log();
    log_id.delete(); log_cyc.delete(); log_err.delete();
    we_cnt = 0;
  endtask

  int t0;

  initial begin
    // Reset state
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_acks", {disp_ack, host_ack, alg_ack}, 0);
    chk("rst_rdata", {disp_rdata, host_rdata, alg_rdata}, 0);
    reset = 0;
    step(2);

    // Host write 100 <- 0x5A
    clear_log(); t0 = cyc;
    host_req = 1; host_we = 1; host_addr = 17'd100; host_wdata = 8'h5A;
    step(1);
    chk("wr_grant", grant_id, 2'b10);
    chk("wr_busy", busy, 1);
    wait_log("wr_timeout", 1);
    chk("wr_id", log_id[0], 2'b10);
    chk("wr_lat", log_cyc[0] - t0 + 1, 5);
    chk("wr_we_cycles", we_cnt, 3);
    host_we = 0;
    step(2);
    chk("wr_idle_busy", busy, 0);
    chk("wr_idle_grant", grant_id, 0);

    // Host read 100
    clear_log(); t0 = cyc;
    host_req = 1; host_addr = 17'd100;
    wait_log("rd_timeout", 1);
    chk("rd_lat", log_cyc[0] - t0 + 1, 5);
    chk("rd_we_cycles", we_cnt, 0);
    chk("rd_data", host_rdata, 8'h5A);
    step(2);

    // Algorithm read of first out-of-range address
    clear_log(); t0 = cyc;
    alg_req = 1; alg_we = 0; alg_addr = 17'd76800;
    wait_log("oor_timeout", 1);
`ifdef VRAM_ARB_RANGE_CHECK_EN
    chk("oor_lat", log_cyc[0] - t0 + 1, 2);
    chk("oor_err", log_err[0], 1);
    chk("oor_rdata", alg_rdata, 0);
    chk("oor_we", we_cnt, 0);
`else
    chk("oor_lat", log_cyc[0] - t0 + 1, 5);
    chk("oor_err", log_err[0], 0);
    chk("oor_addr", mem_addr, 17'd76800);
    chk("oor_rdata", alg_rdata, 8'hEE);
`endif
    step(2);

    // All three at once: D, H, A
    clear_log(); t0 = cyc;
    disp_req = 1; disp_addr = 17'd7;
    host_req = 1; host_addr = 17'd100;
    alg_req = 1; alg_addr = 17'd200;
    wait_log("all3_timeout", 3);
    chk("all3_id0", log_id[0], 2'b01);
    chk("all3_id1", log_id[1], 2'b10);
    chk("all3_id2", log_id[2], 2'b11);
    chk("all3_lat0", log_cyc[0] - t0 + 1, 5);
    chk("all3_lat1", log_cyc[1] - t0 + 1, 10);
    chk("all3_lat2", log_cyc[2] - t0 + 1, 15);
    chk("all3_dr", disp_rdata, 8'hA2);
    chk("all3_hr", host_rdata, 8'h5A);
    chk("all3_ar", alg_rdata, 8'h6D);
    step(2);

    // Sustained host/alg contention
    clear_log(); t0 = cyc; auto_drop = 0;
    host_req = 1; alg_req = 1;
    wait_log("rr_timeout", 6);
    host_req = 0; alg_req = 0; auto_drop = 1;
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_id%0d", i), log_id[i],
          (i % 2 == 0) ? 2'b10 : 2'b11);
    chk("rr_first_lat", log_cyc[0] - t0 + 1, 5);
    chk("rr_span", log_cyc[5] - log_cyc[0], 25);
    step(3);

    // Display arrives during host ACCESS
    clear_log(); t0 = cyc;
    host_req = 1; host_addr = 17'd100;
    step(2);
    disp_req = 1; disp_addr = 17'd7;
    wait_log("pre_timeout", 2);
    chk("pre_id0", log_id[0], 2'b10);
    chk("pre_id1", log_id[1], 2'b01);
    chk("pre_lat1", log_cyc[1] - t0 + 1, 10);
    step(2);

    // Reset in 2nd ACCESS cycle of a write
    clear_log();
    host_req = 1; host_we = 1; host_addr = 17'd300; host_wdata = 8'h33;
    step(2);
    chk("rst_pre_we", mem_we, 1);
    reset = 1; host_req = 0; host_we = 0;
    #1;
    chk("rst_mid_we", mem_we, 0);
    chk("rst_mid_busy", busy, 0);
    step(1);
    reset = 0;
    step(1);
    chk("rst_post_busy", busy, 0);
    chk("rst_post_grant", grant_id, 0);
    step(6);
    chk("rst_no_ack", log_id.size(), 0);

    // rr pointer back at host after reset
    clear_log();
    host_req = 1; host_addr = 17'd100;
    alg_req = 1; alg_addr = 17'd200;
    wait_log("rst_rr_timeout", 2);
    chk("rst_rr_id0", log_id[0], 2'b10);
    chk("rst_rr_id1", log_id[1], 2'b11);
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-owner arbiter for the 320x240, 8-bit frame-buffer RAM port (17-bit address, 76800 words). It shares the one memory port between three requesters: the display scan-out reader, the host read/write interface, and the zoom-algorithm engine. It sequences each granted access through the RAM's fixed read/write latency and returns a one-cycle acknowledge with read data. It sits between those requesters and the frame-buffer RAM; it is the only block driving the RAM address and write-enable.

## Interface
Parameters:
- ADDR_W, 17, address width.
- DATA_W, 8, pixel width.
- MEM_LAT, 3, RAM access cycles that address/we/wdata must be held; legal range 1..15.
- MEM_DEPTH, 76800, number of valid words.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- disp_req / host_req / alg_req  in  1 each  access request; held until the matching ack.
- host_we / alg_we  in  1 each  1 = write, 0 = read. Display is read-only.
- disp_addr / host_addr / alg_addr  in  ADDR_W each  word address.
- host_wdata / alg_wdata  in  DATA_W each  write data.
- disp_ack / host_ack / alg_ack  out  1 each  one-cycle completion pulse.
- disp_rdata / host_rdata / alg_rdata  out  DATA_W each  read data, valid in the ack cycle and held until the next ack to that requester.
- host_err / alg_err  out  1 each  range-error pulse, coincident with ack (see Configuration).
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  2  00 none, 01 display, 10 host, 11 algorithm; the current owner.

## Operation
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- **IDLE:**
  - If any req is high, pick a winner.
  - Display has strict priority.
  - Host and algorithm are round-robin: pointer rr_host_next, reset value 1 (host first). The pointer flips to favour the loser after every host or algorithm grant; it is unchanged by display grants.
  - Latch the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata, set grant_id, load lat_cnt = MEM_LAT-1, and go to ACCESS.
  - If no req is high, stay in IDLE with mem_we = 0.
- **ACCESS:**
  - Hold mem_addr, mem_we and mem_wdata stable.
  - Decrement lat_cnt each cycle.
  - At lat_cnt == 0: capture mem_rdata into the owner's rdata register (reads only; write cycles leave rdata unchanged), drop mem_we, and go to RESP.
- **RESP:**
  - Pulse the owner's ack for one cycle, then go to IDLE.
  - grant_id returns to 00 on leaving RESP.
- No preemption. Display priority applies only at IDLE arbitration.
- A requester must drop req in the cycle after its ack; otherwise the still-high req is treated as a new request.
- Requests arriving during ACCESS/RESP wait for IDLE. Inputs are sampled only in the IDLE cycle.
- Simultaneous host and algorithm requests are resolved by rr_host_next. Under sustained contention they alternate strictly.
- If all three request at once, display is granted first and host/algorithm then follow round-robin.
- Reset mid-access: asynchronously returns to IDLE; mem_we, acks and busy go low immediately; the access is abandoned and no ack is issued.
- Reset values: mem_addr 0, mem_wdata 0, mem_we 0, all acks 0, all rdata 0, errs 0, busy 0, grant_id 00, rr_host_next 1.

## Timing
- Request-to-ack latency is MEM_LAT+2 cycles from the first cycle req is seen high in IDLE (default 5):
  - 1 IDLE cycle,
  - MEM_LAT ACCESS cycles,
  - 1 RESP cycle.
- mem_we is high for exactly MEM_LAT consecutive cycles per write.
- Back-to-back throughput is one access per MEM_LAT+2 cycles. There is no bubble beyond the IDLE arbitration cycle.
- An out-of-range access with the range check compiled in has latency 2: IDLE, then RESP.

## Configuration
- Macro: VRAM_ARB_RANGE_CHECK_EN.
- Defined:
  - A host or algorithm address >= MEM_DEPTH skips ACCESS and performs no RAM cycle; mem_we stays 0.
  - The FSM goes IDLE to RESP; ack and err pulse together, and rdata is forced to 0.
  - Display addresses are not checked.
- Undefined: addresses pass to mem_addr unchanged, err outputs are tied to 0, and the check logic is absent.

## Structure
- Package vram_arb_pkg holds:
  - state encoding (IDLE/ACCESS/RESP),
  - grant_id codes,
  - the FB_WIDTH 320, FB_HEIGHT 240 and FB_WORDS 76800 constants.
- Sub-module vram_arb_rr: combinational winner select from the three reqs plus rr_host_next, returning grant_id. It is kept separate so the policy can be unit-tested alone.

## Test plan
- Host write addr 100, data 0x5A; then host read addr 100 → mem_we high for 3 cycles, host_ack at cycle 5 of each access, host_rdata = 0x5A.
- disp_req, host_req and alg_req all rise in the same cycle → grant order display, host, algorithm; acks at cycles 5, 10 and 15.
- Host and algorithm requesting continuously for 6 accesses → grants alternate H, A, H, A, H, A, with no two consecutive grants to either.
- Display requests during a host ACCESS → host completes and is acked first; display is granted at the next IDLE.
- Reset asserted in the 2nd ACCESS cycle of a write → mem_we drops immediately with no ack; after release, busy = 0, grant_id = 00, and the next host request is granted first.
- With VRAM_ARB_RANGE_CHECK_EN, algorithm read of addr 76800 → alg_ack and alg_err at cycle 2, alg_rdata 0, no mem_we; without the macro, the address is driven on mem_addr and alg_err stays 0.
